// File: rtl/tlb_op_ctrl.sv
// TLB management controller: issues SRCH/RD/WR/FILL/INVTLB over the s0/s1/s2 TLB ports.
// Optional macro TLB_FILL_LFSR_EN: FILL index taken from a free-running LFSR instead of a counter.
module tlb_op_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [2:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_va,
  input  logic [9:0]      csr_asid,
  input  logic [18:0]     csr_vppn,
  input  logic [IDXW-1:0] csr_index,
  input  logic            csr_ne,
  input  logic            csr_g,
  input  logic [25:0]     csr_elo0,
  input  logic [25:0]     csr_elo1,
  output logic [18:0]     s0_VPPN,
  output logic [9:0]      s0_ASID,
  input  logic [IDXW-1:0] s0_index,
  input  logic            s0_NE,
  output logic [IDXW-1:0] s1_index,
  input  logic [9:0]      s1_ASID,
  input  logic            s1_NE,
  input  logic            s1_G,
  input  logic [18:0]     s1_VPPN,
  input  logic [25:0]     s1_phytran0,
  input  logic [25:0]     s1_phytran1,
  output logic            s2_we,
  output logic [IDXW-1:0] s2_index,
  output logic            s2_NE,
  output logic [9:0]      s2_ASID,
  output logic [18:0]     s2_VPPN,
  output logic            s2_G,
  output logic [25:0]     s2_phytran0,
  output logic [25:0]     s2_phytran1,
  output logic            done_valid,
  output logic [IDXW-1:0] res_index,
  output logic            res_ne,
  output logic [9:0]      res_asid,
  output logic [18:0]     res_vppn,
  output logic            res_g,
  output logic [25:0]     res_elo0,
  output logic [25:0]     res_elo1,
  output logic            op_err,
  output logic [2:0]      dbg_state
);

  // Handshake: a request is taken on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE, and every accepted request yields exactly one done_valid pulse.
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_INV_RD, S_INV_WR, S_DONE} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  localparam logic [IDXW-1:0] LAST_IDX = {IDXW{1'b1}};

  state_t          state;
  logic [2:0]      op_q;
  logic [2:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_va_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] walk_i;
  logic [IDXW-1:0] fill_ptr;
  logic            rule_hit;
  logic            inv_hit;
  logic            illegal;

  assign dbg_state = state;
  assign s1_index  = (state == S_INV_RD || state == S_INV_WR) ? walk_i : idx_q;
  assign illegal   = (op_code > OP_INV) || (op_code == OP_INV && inv_op == 3'd7);

  always_comb begin
    rule_hit = 1'b0;
    case (inv_op_q)
      3'd0, 3'd1: rule_hit = 1'b1;
      3'd2:       rule_hit = s1_G;
      3'd3:       rule_hit = !s1_G;
      3'd4:       rule_hit = !s1_G && (s1_ASID == inv_asid_q);
      3'd5:       rule_hit = !s1_G && (s1_ASID == inv_asid_q) && (s1_VPPN == inv_va_q);
      3'd6:       rule_hit = (s1_G || (s1_ASID == inv_asid_q)) && (s1_VPPN == inv_va_q);
      default:    rule_hit = 1'b0;
    endcase
    inv_hit = rule_hit && !s1_NE;
  end

`ifdef TLB_FILL_LFSR_EN
  localparam int LW = (IDXW > 4) ? IDXW : 4;

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      default: return 32'h0000_D008;
    endcase
  endfunction

  localparam logic [31:0] TAPS32 = lfsr_taps(LW);
  logic [LW-1:0] lfsr;

  // Galois form; steps every cycle so the FILL victim is pseudo-random.
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= LW'(1);
    else      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS32[LW-1:0] : '0);
  end
  assign fill_ptr = lfsr[IDXW-1:0];
`else
  logic [IDXW-1:0] fill_cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      fill_cnt <= '0;
    else if (state == S_IDLE && op_valid && op_code == OP_FILL)
      fill_cnt <= fill_cnt + 1'b1;
  end
  assign fill_ptr = fill_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_ready    <= 1'b1;
      done_valid  <= 1'b0;
      op_err      <= 1'b0;
      op_q        <= '0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_va_q    <= '0;
      idx_q       <= '0;
      walk_i      <= '0;
      s0_VPPN     <= '0;
      s0_ASID     <= '0;
      s2_we       <= 1'b0;
      s2_index    <= '0;
      s2_NE       <= 1'b0;
      s2_ASID     <= '0;
      s2_VPPN     <= '0;
      s2_G        <= 1'b0;
      s2_phytran0 <= '0;
      s2_phytran1 <= '0;
      res_index   <= '0;
      res_ne      <= 1'b0;
      res_asid    <= '0;
      res_vppn    <= '0;
      res_g       <= 1'b0;
      res_elo0    <= '0;
      res_elo1    <= '0;
    end else begin
      done_valid <= 1'b0;
      op_err     <= 1'b0;
      s2_we      <= 1'b0;
      case (state)
        S_IDLE: if (op_valid) begin
          op_ready   <= 1'b0;
          op_q       <= op_code;
          inv_op_q   <= inv_op;
          inv_asid_q <= inv_asid;
          inv_va_q   <= inv_va;
          idx_q      <= csr_index;
          s0_VPPN    <= csr_vppn;
          s0_ASID    <= csr_asid;
          if (illegal) begin
            state      <= S_DONE;
            done_valid <= 1'b1;
            op_err     <= 1'b1;
          end else if (op_code == OP_INV) begin
            walk_i <= '0;
            state  <= S_INV_RD;
          end else begin
            state <= S_EXEC;
            if (op_code == OP_WR || op_code == OP_FILL) begin
              s2_we       <= 1'b1;
              s2_index    <= (op_code == OP_FILL) ? fill_ptr : csr_index;
              s2_NE       <= ~csr_ne;
              s2_ASID     <= csr_asid;
              s2_VPPN     <= csr_vppn;
              s2_G        <= csr_g;
              s2_phytran0 <= csr_elo0;
              s2_phytran1 <= csr_elo1;
            end
          end
        end
        S_EXEC: begin
          state      <= S_DONE;
          done_valid <= 1'b1;
          case (op_q)
            OP_SRCH: begin
              res_ne <= s0_NE;
              if (!s0_NE) res_index <= s0_index;
            end
            OP_RD: begin
              res_ne   <= s1_NE;
              res_asid <= s1_NE ? '0   : s1_ASID;
              res_vppn <= s1_NE ? '0   : s1_VPPN;
              res_g    <= s1_NE ? 1'b0 : s1_G;
              res_elo0 <= s1_NE ? '0   : s1_phytran0;
              res_elo1 <= s1_NE ? '0   : s1_phytran1;
            end
            OP_FILL: res_index <= s2_index;
            default: ;
          endcase
        end
        S_INV_RD: begin
          if (inv_hit) begin
            // Rewrite the entry unchanged except for its valid bit.
            s2_we       <= 1'b1;
            s2_index    <= walk_i;
            s2_NE       <= 1'b0;
            s2_ASID     <= s1_ASID;
            s2_VPPN     <= s1_VPPN;
            s2_G        <= s1_G;
            s2_phytran0 <= s1_phytran0;
            s2_phytran1 <= s1_phytran1;
            state       <= S_INV_WR;
          end else if (walk_i == LAST_IDX) begin
            state      <= S_DONE;
            done_valid <= 1'b1;
          end else begin
            walk_i <= walk_i + 1'b1;
          end
        end
        S_INV_WR: begin
          if (walk_i == LAST_IDX) begin
            state      <= S_DONE;
            done_valid <= 1'b1;
          end else begin
            walk_i <= walk_i + 1'b1;
            state  <= S_INV_RD;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Initiator side of the TLB port set. Accepts one TLB-management instruction at a time from the EX/MEM pipeline stage: TLBSRCH, TLBRD, TLBWR, TLBFILL or INVTLB.
- Drives the TLB search (s0), read (s1) and write (s2) ports, then returns CSR-update results to the pipeline.
- INVTLB is executed as a sequential read-compare-clear walk over all entries, so the TLB needs no separate flush port.

Parameters:
- TLBNUM, 16, number of TLB entries; must be a power of 2 and at least 2.
- IDXW, $clog2(TLBNUM), index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on the rising edge of clk)
- op_valid  in  1  instruction request
- op_ready  out  1  controller idle; accepts a request this cycle
- op_code  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV; values 5..7 are illegal
- inv_op  in  3  INVTLB op field
- inv_asid  in  10  INVTLB ASID operand
- inv_va  in  19  INVTLB VPPN operand
- csr_asid  in  10  CSR.ASID.ASID
- csr_vppn  in  19  CSR.TLBEHI.VPPN
- csr_index  in  IDXW  CSR.TLBIDX.Index
- csr_ne  in  1  CSR.TLBIDX.NE
- csr_g  in  1  write G bit
- csr_elo0, csr_elo1  in  26  {V,D,MAT[1:0],PLV[1:0],PPN[19:0]}
- s0_VPPN  out  19; s0_ASID  out  10; s0_index  in  IDXW; s0_NE  in  1
- s1_index  out  IDXW; s1_ASID  in  10; s1_NE  in  1; s1_G  in  1; s1_VPPN  in  19; s1_phytran0, s1_phytran1  in  26
- s2_we  out  1; s2_index  out  IDXW; s2_NE  out  1 (drives entry E, 1=valid); s2_ASID  out  10; s2_VPPN  out  19; s2_G  out  1; s2_phytran0, s2_phytran1  out  26
- done_valid  out  1  one-cycle completion pulse
- res_index  out  IDXW; res_ne  out  1; res_asid  out  10; res_vppn  out  19; res_g  out  1; res_elo0, res_elo1  out  26
- op_err  out  1  valid with done_valid: illegal op_code or inv_op>6

Behaviour:
- Reset: state=IDLE, op_ready=1, done_valid=0, op_err=0, s2_we=0, all res_* =0, walk counter=0, fill pointer=0.
- A mid-operation reset abandons the operation: no further s2_we, no done_valid.
- Handshake:
  - Accept when op_valid && op_ready. Operands are captured on accept.
  - op_ready=1 only in IDLE; op_valid while busy is ignored.
- FSM: IDLE -> EXEC (SRCH/RD/WR/FILL) or INV_RD (INV) -> ... -> DONE -> IDLE.
- DONE lasts 1 cycle with done_valid=1. op_ready returns the cycle after DONE.
- SRCH:
  - EXEC drives s0_VPPN=csr_vppn and s0_ASID=csr_asid.
  - Registers res_ne=s0_NE and res_index=s0_index (res_index holds its old value if NE).
  - done_valid 2 cycles after accept.
- RD:
  - EXEC drives s1_index=csr_index.
  - If !s1_NE: capture res_asid, res_vppn, res_g, res_elo0/1 from s1, and res_ne=0.
  - Else res_ne=1 and the other res fields are cleared to 0.
  - Latency 2.
- WR: EXEC pulses s2_we for 1 cycle, with s2_index=csr_index, s2_NE=~csr_ne, fields from CSRs. Latency 2.
- FILL:
  - Same as WR but s2_index=fill pointer, and res_index=that pointer.
  - Fill pointer advances by 1 modulo TLBNUM on each FILL, wrapping TLBNUM-1 -> 0.
- INV, walk counter i = 0..TLBNUM-1:
  - INV_RD drives s1_index=i.
  - Match requires !s1_NE plus the op rule:
    - op0, op1: always.
    - op2: G=1.
    - op3: G=0.
    - op4: G=0 && ASID==inv_asid.
    - op5: G=0 && ASID==inv_asid && VPPN==inv_va.
    - op6: (G=1 || ASID==inv_asid) && VPPN==inv_va.
  - On match -> INV_WR. INV_WR pulses s2_we for entry i with s2_NE=0 and all other fields copied from the captured s1 values, then continues.
  - On no match, i increments immediately.
  - After i=TLBNUM-1 -> DONE.
  - Latency is TLBNUM+matches+1 cycles to done_valid.
- Illegal op_code or inv_op>6: no s2_we; go directly to DONE with op_err=1. Latency 1.
- Hold: res_* hold between operations. done_valid never asserts back-to-back.

Optional Feature:
- TLB_FILL_LFSR_EN defined: the fill pointer is a max-length LFSR of width max(IDXW,4) seeded to 1 on reset. The low IDXW bits select the index; the LFSR steps once per clk when not in reset.
- Undefined: a sequential counter that advances only on FILL.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> op_ready=1, done_valid=0, s2_we=0, res_*=0.
- WR then SRCH:
  - WR with csr_index=5, csr_vppn=0x1234, csr_asid=3, csr_ne=0 -> one s2_we pulse at index 5, s2_NE=1.
  - SRCH with the same VPPN/ASID -> done 2 cycles after accept, res_ne=0, res_index=5.
- RD of an empty entry: csr_index=7 never written -> res_ne=1, res_asid=0, res_elo0=0.
- FILL wrap (counter build): 17 FILLs from reset -> indices 0..15, then 0; res_index matches each s2_index.
- INV op5:
  - Setup: entries 2 (G=0, ASID=3, VPPN=0x10), 4 (G=1, ASID=3, VPPN=0x10), 9 (G=0, ASID=4, VPPN=0x10).
  - inv_asid=3, inv_va=0x10 -> only entry 2 cleared, done after 18 cycles; then SRCH ASID=3 VPPN=0x10 -> res_index=4.
- Illegal op: inv_op=7 -> no s2_we, done 1 cycle after accept, op_err=1. Also assert rst=0 during an op0 walk at i=6 -> no further writes, IDLE next cycle.
